// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a bounded hold time, registered one-hot grant and a wrapping grant-event count.
// Latency: a request sampled at an edge is granted at that edge. No backpressure: the owner holds until it drops or is rotated out.
module rr_grant_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    win;
  logic             win_vld;
  logic [7:0]       hold_q, hold_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic             own_req, others, take;
  int               idx;

  // First set request at or above ptr, wrapping modulo N_REQ.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_vld && req_i[IW'(idx)]) begin
        win     = IW'(idx);
        win_vld = 1'b1;
      end
    end
  end

  // The one-hot grant register doubles as the owner index.
  assign own_req = |(req_i & grant_q);
  assign others  = |(req_i & ~grant_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // take marks a grant event: a new owner, always different from the current one.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          take    = 1'b1;
        end
      end
      GRANT: begin
        if (!own_req) begin
          if (win_vld) take = 1'b1;
          else         state_d = IDLE;
        end else if (hold_q == HOLD_LAST && others) begin
          take = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    hold_d  = hold_q;
    if (take) begin
      grant_d = N_REQ'(1) << win;
      hold_d  = '0;
    end else if (state_d == IDLE) begin
      grant_d = '0;
      hold_d  = '0;
    end else if (hold_q == HOLD_LAST) begin
      hold_d  = '0;
    end else begin
      hold_d  = hold_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      grant_q <= grant_d;
      busy_q  <= |grant_d;
      hold_q  <= hold_d;
      if (take) begin
        ptr_q <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = busy_q;
  assign cnt_o   = cnt_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: a behavioural model pushes expected outputs per edge, checked after the edge.
module tb_rr_grant_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_i = 4'b0000;
  logic [3:0] grant_o;
  logic       busy_o;
  logic [3:0] cnt_o;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] g;
    logic       b;
    logic [3:0] c;
  } exp_t;

  exp_t exp_q[$];

  // Model state
  logic [3:0] m_grant = 4'b0000;
  logic [3:0] m_cnt   = 4'd0;
  int         m_ptr   = 0;
  int         m_hold  = 0;

  rr_grant_arbiter #(.N_REQ(4), .MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_i),
    .grant_o (grant_o),
    .busy_o  (busy_o),
    .cnt_o   (cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic model_edge(input logic r_rst, input logic [3:0] r);
    logic [3:0] new_g;
    logic [1:0] k2;
    logic       found;
    int         w;
    exp_t       e;
    found = 1'b0;
    w     = 0;
    if (r_rst) begin
      m_grant = 4'b0000;
      m_cnt   = 4'd0;
      m_ptr   = 0;
      m_hold  = 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        k2 = 2'((m_ptr + k) % 4);
        if (!found && r[k2]) begin
          w     = int'(k2);
          found = 1'b1;
        end
      end
      new_g = m_grant;
      if (m_grant == 4'b0000) begin
        if (found) new_g = 4'b0001 << w;
        m_hold = 0;
      end else if ((r & m_grant) == 4'b0000) begin
        new_g  = found ? (4'b0001 << w) : 4'b0000;
        m_hold = 0;
      end else if (m_hold < MAX_HOLD - 1) begin
        m_hold++;
      end else begin
        m_hold = 0;
        if ((r & ~m_grant) != 4'b0000) new_g = 4'b0001 << w;
      end
      if (new_g != 4'b0000 && new_g != m_grant) begin
        m_cnt = m_cnt + 4'd1;
        m_ptr = (w + 1) % 4;
      end
      m_grant = new_g;
    end
    e.g = m_grant;
    e.b = |m_grant;
    e.c = m_cnt;
    exp_q.push_back(e);
  endtask

  // Drive one edge's inputs, predict, then compare the DUT with the popped prediction.
  task automatic step(input logic r_rst, input logic [3:0] r);
    exp_t e;
    @(negedge clk);
    rst   = r_rst;
    req_i = r;
    model_edge(r_rst, r);
    @(posedge clk);
    #1;
    checks++;
    assert (exp_q.size() > 0) else begin
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_grant", grant_o, e.g);
      chk("sb_busy", {3'b000, busy_o}, {3'b000, e.b});
      chk("sb_cnt", cnt_o, e.c);
    end
  endtask

  initial begin
    // Reset with all requests asserted.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b1111);
      chk("rst_grant", grant_o, 4'b0000);
      chk("rst_cnt", cnt_o, 4'd0);
      chk("rst_busy", {3'b000, busy_o}, 4'b0000);
    end
    step(1'b0, 4'b1111);
    chk("first_grant", grant_o, 4'b0001);
    chk("first_cnt", cnt_o, 4'd1);

    // Grant from idle, then release.
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0100);
    chk("idle_grant", grant_o, 4'b0100);
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0000);
    chk("release_grant", grant_o, 4'b0000);
    chk("release_cnt", cnt_o, 4'd1);
    chk("release_busy", {3'b000, busy_o}, 4'b0000);

    // Full contention: each owner holds exactly MAX_HOLD cycles.
    step(1'b1, 4'b0000);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 4'b1111);
      chk("rr_grant", grant_o, 4'b0001 << ((i / MAX_HOLD) % 4));
      chk("rr_cnt", cnt_o, 4'((i / MAX_HOLD) + 1));
    end

    // Sole requester: hold restarts without a new event.
    step(1'b1, 4'b0000);
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 4'b0010);
      chk("solo_grant", grant_o, 4'b0010);
      chk("solo_cnt", cnt_o, 4'd1);
    end

    // Pulsed requests wrap the counter.
    step(1'b1, 4'b0000);
    for (int j = 0; j < 17; j++) begin
      step(1'b0, 4'b0001);
      chk("pulse_cnt", cnt_o, 4'((j + 1) % 16));
      step(1'b0, 4'b0000);
      chk("pulse_idle", grant_o, 4'b0000);
    end

    // Owner drop with others waiting hands over without a bubble; reset mid-grant.
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0001);
    chk("handover_pre", grant_o, 4'b0001);
    step(1'b0, 4'b1010);
    chk("handover_grant", grant_o, 4'b0010);
    chk("handover_cnt", cnt_o, 4'd2);
    step(1'b1, 4'b1010);
    chk("midrst_grant", grant_o, 4'b0000);
    chk("midrst_cnt", cnt_o, 4'd0);

    // Random traffic with occasional reset, checked against the model only.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 49) == 0, 4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
